// File: rtl/adder_result_checker.sv
// adder_result_checker: compares an adder DUT's {carry,sum} against the
// expected value of each operand pair after a fixed DUT latency, and
// reports saturating pass/fail counts plus the first failing vector.
module adder_result_checker #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             ff_valid,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH:0]   ff_exp,
  output logic [WIDTH:0]   ff_got
);

  // DRAIN must cover the last vector captured in the stop cycle; a
  // combinational DUT still gets one DRAIN cycle.
  localparam int DRAIN_LEN = (LATENCY == 0) ? 1 : LATENCY;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_next;
  logic [2:0] r_drain_cnt;
  logic r_busy, r_done, r_err, r_ff_valid;
  logic [CNT_W-1:0] r_pass, r_fail;
  logic [WIDTH-1:0] r_ff_a, r_ff_b;
  logic [WIDTH:0]   r_ff_exp, r_ff_got;

  logic             w_capture;
  logic [WIDTH:0]   w_exp, w_got;
  logic             w_tail_vld;
  logic [WIDTH-1:0] w_tail_a, w_tail_b;
  logic [WIDTH:0]   w_tail_exp;
  logic             w_match;

  assign w_capture = (r_state == S_RUN) && op_valid;
  assign w_exp     = {1'b0, op_a} + {1'b0, op_b};
  assign w_got     = {dut_carry, dut_sum};

  generate
    if (LATENCY == 0) begin : g_comb
      assign w_tail_vld = w_capture;
      assign w_tail_a   = op_a;
      assign w_tail_b   = op_b;
      assign w_tail_exp = w_exp;
    end else begin : g_pipe
      logic [LATENCY-1:0]            r_vld;
      logic [LATENCY-1:0][WIDTH-1:0] r_a, r_b;
      logic [LATENCY-1:0][WIDTH:0]   r_e;

      // Expected-value delay line; start flushes in-flight vectors.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_vld <= '0;
          r_a   <= '0;
          r_b   <= '0;
          r_e   <= '0;
        end else begin
          r_vld[0] <= w_capture && !start;
          r_a[0]   <= op_a;
          r_b[0]   <= op_b;
          r_e[0]   <= w_exp;
          for (int i = 1; i < LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1] && !start;
            r_a[i]   <= r_a[i-1];
            r_b[i]   <= r_b[i-1];
            r_e[i]   <= r_e[i-1];
          end
        end
      end

      assign w_tail_vld = r_vld[LATENCY-1];
      assign w_tail_a   = r_a[LATENCY-1];
      assign w_tail_b   = r_b[LATENCY-1];
      assign w_tail_exp = r_e[LATENCY-1];
    end
  endgenerate

  assign w_match = (w_got == w_tail_exp);

  // Next-state logic; start has priority over stop everywhere.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (start) w_next = S_RUN;
               else if (stop) w_next = S_DRAIN;
      S_DRAIN: if (start) w_next = S_RUN;
               else if (r_drain_cnt == 3'(DRAIN_LEN - 1)) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // State register, drain timer and registered status decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_drain_cnt <= (r_state == S_DRAIN && w_next == S_DRAIN) ? r_drain_cnt + 3'd1 : 3'd0;
      r_busy      <= (w_next == S_RUN) || (w_next == S_DRAIN);
      r_done      <= (w_next == S_DONE);
    end
  end

  // Result bookkeeping: saturating counts, sticky err, first-fail capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pass     <= '0;
      r_fail     <= '0;
      r_err      <= 1'b0;
      r_ff_valid <= 1'b0;
      r_ff_a     <= '0;
      r_ff_b     <= '0;
      r_ff_exp   <= '0;
      r_ff_got   <= '0;
    end else if (start) begin
      r_pass     <= '0;
      r_fail     <= '0;
      r_err      <= 1'b0;
      r_ff_valid <= 1'b0;
      r_ff_a     <= '0;
      r_ff_b     <= '0;
      r_ff_exp   <= '0;
      r_ff_got   <= '0;
    end else if (w_tail_vld) begin
      if (w_match) begin
        if (r_pass != CNT_MAX) r_pass <= r_pass + CNT_W'(1);
      end else begin
        if (r_fail != CNT_MAX) r_fail <= r_fail + CNT_W'(1);
        r_err <= 1'b1;
        if (!r_ff_valid) begin
          r_ff_valid <= 1'b1;
          r_ff_a     <= w_tail_a;
          r_ff_b     <= w_tail_b;
          r_ff_exp   <= w_tail_exp;
          r_ff_got   <= w_got;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign pass_cnt = r_pass;
  assign fail_cnt = r_fail;
  assign ff_valid = r_ff_valid;
  assign ff_a     = r_ff_a;
  assign ff_b     = r_ff_b;
  assign ff_exp   = r_ff_exp;
  assign ff_got   = r_ff_got;

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: one combinational-DUT instance (8-bit
// counters) and one 3-cycle-DUT instance (4-bit counters) share stimulus.
module tb_adder_result_checker;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, op_valid = 1'b0;
  logic [3:0] op_a = '0, op_b = '0;
  logic fbad = 1'b0;
  int n_chk = 0, n_err = 0;
  logic [8:0] vq[$];  // {bad,a,b} of vectors sent in the current run

  always #5 clk = ~clk;

  // Emulated adder DUTs; fbad flips sum bit 0 for the marked vector.
  logic [4:0] s0, s3;
  logic [3:0] ma[3], mb[3];
  logic       mbad[3];
  assign s0 = ({1'b0, op_a} + {1'b0, op_b}) ^ {4'b0, fbad};
  always @(posedge clk) begin
    ma[0] <= op_a; mb[0] <= op_b; mbad[0] <= fbad;
    for (int i = 1; i < 3; i++) begin
      ma[i] <= ma[i-1]; mb[i] <= mb[i-1]; mbad[i] <= mbad[i-1];
    end
  end
  assign s3 = ({1'b0, ma[2]} + {1'b0, mb[2]}) ^ {4'b0, mbad[2]};

  logic busy0, done0, err0, ffv0, busy3, done3, err3, ffv3;
  logic [7:0] pc0, fc0;
  logic [3:0] pc3, fc3, ffa0, ffb0, ffa3, ffb3;
  logic [4:0] ffe0, ffg0, ffe3, ffg3;

  adder_result_checker #(.WIDTH(4), .LATENCY(0), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .op_valid(op_valid),
    .op_a(op_a), .op_b(op_b), .dut_sum(s0[3:0]), .dut_carry(s0[4]),
    .busy(busy0), .done(done0), .err(err0), .pass_cnt(pc0), .fail_cnt(fc0),
    .ff_valid(ffv0), .ff_a(ffa0), .ff_b(ffb0), .ff_exp(ffe0), .ff_got(ffg0));

  adder_result_checker #(.WIDTH(4), .LATENCY(3), .CNT_W(4)) u3 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .op_valid(op_valid),
    .op_a(op_a), .op_b(op_b), .dut_sum(s3[3:0]), .dut_carry(s3[4]),
    .busy(busy3), .done(done3), .err(err3), .pass_cnt(pc3), .fail_cnt(fc3),
    .ff_valid(ffv3), .ff_a(ffa3), .ff_b(ffb3), .ff_exp(ffe3), .ff_got(ffg3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic with_stop);
    start = 1'b1; stop = with_stop; cyc(); start = 1'b0; stop = 1'b0;
    vq.delete();
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic bad, input logic rec);
    op_valid = 1'b1; op_a = a; op_b = b; fbad = bad;
    if (rec) vq.push_back({bad, a, b});
    cyc();
    op_valid = 1'b0; fbad = 1'b0;
  endtask

  // Stop, then count busy cycles per instance until both report done.
  task automatic do_stop(input string t);
    int d0 = 0, d3 = 0;
    stop = 1'b1; cyc(); stop = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (busy0) d0++;
      if (busy3) d3++;
      if (done0 && done3) break;
      cyc();
    end
    chk({t, ".done0"}, done0, 1);
    chk({t, ".done3"}, done3, 1);
    chk({t, ".drain0"}, d0, 1);
    chk({t, ".drain3"}, d3, 3);
    chk({t, ".idlebusy"}, {busy0, busy3}, 0);
  endtask

  // Expected final status derived from the list of vectors in this run.
  task automatic chk_run(input string t);
    int g = 0, b = 0;
    logic fv = 1'b0;
    logic [3:0] fa = '0, fb = '0;
    logic [4:0] fe = '0, fg = '0;
    foreach (vq[i]) begin
      if (vq[i][8]) begin
        b++;
        if (!fv) begin
          fv = 1'b1; fa = vq[i][7:4]; fb = vq[i][3:0];
          fe = {1'b0, fa} + {1'b0, fb}; fg = fe ^ 5'd1;
        end
      end else g++;
    end
    chk({t, ".pass0"}, pc0, (g > 255) ? 255 : g);
    chk({t, ".pass3"}, pc3, (g > 15) ? 15 : g);
    chk({t, ".fail0"}, fc0, (b > 255) ? 255 : b);
    chk({t, ".fail3"}, fc3, (b > 15) ? 15 : b);
    chk({t, ".err0"}, err0, b > 0);
    chk({t, ".err3"}, err3, b > 0);
    chk({t, ".ff0"}, {ffv0, ffa0, ffb0, ffe0, ffg0}, {fv, fa, fb, fe, fg});
    chk({t, ".ff3"}, {ffv3, ffa3, ffb3, ffe3, ffg3}, {fv, fa, fb, fe, fg});
  endtask

  task automatic chk_zero(input string t);
    chk({t, ".z0"}, {busy0, done0, err0, pc0, fc0, ffv0, ffa0, ffb0, ffe0, ffg0}, 0);
    chk({t, ".z3"}, {busy3, done3, err3, pc3, fc3, ffv3, ffa3, ffb3, ffe3, ffg3}, 0);
  endtask

  logic [3:0] ta[4], tb[4];
  int lat_done;

  initial begin
    ta[0] = 4'h0; tb[0] = 4'h4; ta[1] = 4'h3; tb[1] = 4'hA;
    ta[2] = 4'h7; tb[2] = 4'h4; ta[3] = 4'h5; tb[3] = 4'hB;

    // Reset state, then op_valid pulses in IDLE must be ignored.
    cyc(); cyc();
    chk_zero("reset");
    reset = 1'b0;
    cyc();
    send(4'h1, 4'h2, 1'b0, 1'b0);
    send(4'h3, 4'h4, 1'b1, 1'b0);
    cyc(); cyc(); cyc();
    chk_zero("idle_ops");

    // T1: directed vectors, all correct; watch result latency per instance.
    do_start(1'b0);
    chk("t1.busy", {busy0, done0, busy3, done3}, 4'b1010);
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb[i], 1'b0, 1'b1);
      lat_done = (i >= 2) ? i - 2 : 0;
      chk($sformatf("t1.lat0_%0d", i), pc0, i + 1);
      chk($sformatf("t1.lat3_%0d", i), pc3, lat_done);
    end
    do_stop("t1");
    chk_run("t1");

    // T2: same vectors, (5,B) returns exp^1.
    do_start(1'b0);
    for (int i = 0; i < 4; i++) send(ta[i], tb[i], i == 3, 1'b1);
    do_stop("t2");
    chk_run("t2");

    // T3: 10 random back-to-back correct vectors.
    do_start(1'b0);
    chk("t3.clr", {err0, fc0, ffv0, err3, fc3, ffv3}, 0);
    for (int i = 0; i < 10; i++)
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b1);
    do_stop("t3");
    chk_run("t3");

    // T4: 20 correct then 2 faulty; the 4-bit pass counter saturates.
    do_start(1'b0);
    for (int i = 0; i < 20; i++)
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b1);
    do_stop("t4");
    chk_run("t4");

    // Pulses while DONE are not counted; results hold.
    send(4'h2, 4'h2, 1'b1, 1'b0);
    send(4'h6, 4'h1, 1'b0, 1'b0);
    cyc(); cyc(); cyc();
    chk_run("t4.hold");

    // T5: restart with vectors in flight (start+stop together, start wins),
    // then two faults with gaps; only the first is captured.
    do_start(1'b0);
    send(4'h9, 4'h9, 1'b0, 1'b1);
    send(4'h8, 4'h1, 1'b1, 1'b1);
    do_start(1'b1);
    chk("t5.restart", {busy0, pc0, fc0, busy3, pc3, fc3}, {1'b1, 16'h0, 1'b1, 8'h0});
    cyc(); cyc(); cyc(); cyc();
    chk("t5.flush", {err0, pc0, fc0, err3, pc3, fc3}, 0);
    send(4'h3, 4'hA, 1'b1, 1'b1);
    cyc();
    send(4'h7, 4'h4, 1'b1, 1'b1);
    cyc();
    do_stop("t5");
    chk_run("t5");

    // T6: async reset mid-RUN clears everything immediately.
    do_start(1'b0);
    for (int i = 0; i < 4; i++) send(ta[i], tb[i], 1'b0, 1'b1);
    chk("t6.pre", {pc0, pc3}, {8'd4, 4'd1});
    #2 reset = 1'b1;
    #1 chk_zero("t6.rst");
    #2 reset = 1'b0;
    cyc();
    chk_zero("t6.post");
    do_start(1'b0);
    send(4'hC, 4'h5, 1'b0, 1'b1);
    do_stop("t6");
    chk_run("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
